mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256; number of 32-bit words in backing store, power of two, 2..65536.
REQ-002 Parameter LATENCY, default 2; cycles from request accept to response valid, range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i covers bits [8i+7:8i].
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load data.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The block SHALL implement states IDLE, BUSY, RESP with one outstanding request at most.
REQ-016 In IDLE: req_ready=1, resp_valid=0; all other states: req_ready=0.
REQ-017 Accept = req_valid & req_ready at a rising edge; it SHALL capture req_we, req_addr, req_wdata, req_be and move to BUSY with counter = LATENCY-1.
REQ-018 In BUSY: counter nonzero -> decrement, stay; counter zero -> perform access, move to RESP.
REQ-019 resp_valid SHALL first be 1 in the cycle after edge E0+LATENCY, where E0 is the accept edge.
REQ-020 Word index = addr[31:2]; error when addr[1:0] != 0 or addr[31:2] >= DEPTH.
REQ-021 Error request: no storage change, resp_err=1, resp_rdata=0.
REQ-022 Valid store: update only bytes with req_be[i]=1; resp_err=0, resp_rdata=0; req_be=0 completes as no-op with normal response.
REQ-023 Valid load: resp_rdata = full stored word sampled at the access edge, resp_err=0; req_be ignored.
REQ-024 In RESP: resp_valid, resp_rdata, resp_err SHALL hold stable until resp_ready=1; then the next edge goes to IDLE and clears resp_valid.
REQ-025 No request is accepted in the same cycle as a response handshake; minimum spacing between accepts = LATENCY+2 cycles.
REQ-026 req_* inputs SHALL be ignored outside IDLE; changes after accept SHALL not affect the in-flight access.
REQ-027 Storage contents are uninitialised (not cleared by reset) and SHALL retain writes indefinitely.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, counter=0, resp_valid=0, resp_err=0, resp_rdata=0, with req_ready=1 the cycle after rst deasserts.
REQ-029 Reset during BUSY SHALL abandon the request; a store not yet at its access edge SHALL NOT modify storage.
REQ-030 Reset during RESP SHALL drop the pending response; the completed store remains in storage.
REQ-031 rst has priority over every handshake sampled at the same edge.

Verification
REQ-032 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 0xF accepted at edge 0 -> resp_valid=1 after edge 2, resp_err=0; then load 0x10 -> resp_rdata 0xDEADBEEF.
REQ-033 Partial store: word 0x10 = 0xDEADBEEF, store 0x00001200 with be 0x2 -> load 0x10 returns 0xDEAD12EF.
REQ-034 Errors, DEPTH=256: load 0x12 -> resp_err=1, rdata 0; store 0x400 -> resp_err=1, and load 0x0 afterwards returns the prior value unchanged.
REQ-035 Backpressure: resp_ready held 0 for 5 cycles -> resp_valid, rdata, err stable all 5 cycles, req_ready=0; resp_ready=1 -> IDLE next edge, req_ready=1.
REQ-036 Reset mid-op: store 0x20 = 0x12345678 accepted, rst=1 at edge 1 with LATENCY=3 -> IDLE, no response, load 0x20 returns the old value.
REQ-037 LATENCY=1 sweep: 100 random aligned in-range loads/stores with random resp_ready compared against a reference model; resp_valid exactly 1 edge after BUSY entry.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder backed by a
// DEPTH x 32-bit word store, with a fixed LATENCY from accept to response.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (ready only while idle)
//   req_we              - 1 = store, 0 = load
//   req_addr            - byte address (word index = addr[31:2])
//   req_wdata, req_be   - store data and per-byte enables
//   resp_valid/ready    - response handshake
//   resp_rdata          - load data (zero for stores and errors)
//   resp_err            - misaligned or out-of-range request
module mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Backing store: deliberately not reset, contents persist across resets.
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          addr_err;
  logic [31:0]   be_mask;
  logic [31:0]   cur_word;
  logic [31:0]   mem_wdata;
  logic          mem_we;

  // Address decode and byte merge operate on the captured request, so input
  // changes after accept cannot disturb the in-flight access.
  always_comb begin
    idx       = addr_q[AW+1:2];
    addr_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);
    cur_word  = mem_q[idx];
    be_mask   = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    mem_wdata = (cur_word & ~be_mask) | (wdata_q & be_mask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          err_d   = addr_err;
          rdata_d = (!addr_err && !we_q) ? cur_word : '0;
          mem_we  = !addr_err && we_q;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset suppresses a store that would otherwise land on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[idx] <= mem_wdata;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (LATENCY 2, 1, 3) driven by
// directed steps plus a randomized sweep checked against a word-level model.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [2:0][31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0][3:0]  req_be;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference store keyed by instance*65536 + word index.
  logic [31:0] mdl [int];

  mem_responder #(.DEPTH(256), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_be(req_be[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  mem_responder #(.DEPTH(64), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_be(req_be[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  mem_responder #(.DEPTH(256), .LATENCY(3)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_be(req_be[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int depth_of(input int k);
    return (k == 1) ? 64 : 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rd, output logic er);
    int key;
    logic [31:0] w;
    er = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(depth_of(k)));
    rd = '0;
    if (!er) begin
      key = k * 65536 + int'(addr >> 2);
      w = mdl.exists(key) ? mdl[key] : 32'h0;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        mdl[key] = w;
      end else begin
        rd = w;
      end
    end
  endtask

  task automatic op(input int k, input bit we, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [3:0] be, input int hold,
                    output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    chk("ready_idle", {31'b0, req_ready[k]}, 32'd1);
    req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_be[k] = be;
    req_valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble request lines; the captured request must be unaffected.
    req_valid[k] = 1'b0;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_be[k]    = 4'($urandom);
    chk("ready_busy", {31'b0, req_ready[k]}, 32'd0);
    n = 0;
    while (!resp_valid[k] && n < 40) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk("latency", 32'(n), 32'(lat_of(k)));
    rd = resp_rdata[k];
    er = resp_err[k];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", {31'b0, resp_valid[k]}, 32'd1);
      chk("hold_rdata", resp_rdata[k], rd);
      chk("hold_err",   {31'b0, resp_err[k]}, {31'b0, er});
      chk("hold_ready", {31'b0, req_ready[k]}, 32'd0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready[k] = 1'b0;
    chk("valid_cleared", {31'b0, resp_valid[k]}, 32'd0);
    chk("ready_after",   {31'b0, req_ready[k]}, 32'd1);
  endtask

  task automatic tchk(input int k, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      input string tag, output logic [31:0] rd);
    logic [31:0] erd;
    logic        eer, er;
    model(k, we, addr, wdata, be, erd, eer);
    op(k, we, addr, wdata, be, hold, rd, er);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, eer});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;
    int widx;
    bit we;
    rst = '1; req_valid = '0; resp_ready = '0; req_we = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {31'b0, req_ready[k]}, 32'd1);
      chk("rst_valid", {31'b0, resp_valid[k]}, 32'd0);
      chk("rst_err",   {31'b0, resp_err[k]}, 32'd0);
      chk("rst_rdata", resp_rdata[k], 32'd0);
    end
    rst = '0;
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 3; k++) chk("post_rst_ready", {31'b0, req_ready[k]}, 32'd1);

    // Full store then load back.
    tchk(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10", rd);
    tchk(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "ld10", rd);
    chk("ld10_const", rd, 32'hDEADBEEF);
    // Partial store on byte 1.
    tchk(0, 1'b1, 32'h10, 32'h00001200, 4'h2, 0, "st10_be2", rd);
    tchk(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, "ld10_part", rd);
    chk("ld10_part_const", rd, 32'hDEAD12EF);
    // Errors and range boundaries.
    tchk(0, 1'b1, 32'h0, 32'hA5A50F0F, 4'hF, 0, "st0", rd);
    tchk(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, "ld_misal", rd);
    tchk(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, "st_oor", rd);
    tchk(0, 1'b1, 32'h1, 32'h11223344, 4'hF, 0, "st_misal", rd);
    tchk(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, "ld0_kept", rd);
    chk("ld0_const", rd, 32'hA5A50F0F);
    tchk(0, 1'b1, 32'h3FC, 32'h600DF00D, 4'hF, 0, "st_last", rd);
    tchk(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, "ld_last", rd);
    tchk(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, "ld_high", rd);
    tchk(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 0, "st_be0", rd);
    tchk(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, "ld0_be0", rd);
    // Backpressure for 5 cycles.
    tchk(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, "ld_bp", rd);

    // Reset during BUSY abandons the store.
    tchk(2, 1'b1, 32'h20, 32'h11111111, 4'hF, 0, "st20_old", rd);
    @(negedge clk);
    req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'h12345678; req_be[2] = 4'hF;
    req_valid[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid[2] = 1'b0; rst[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst[2] = 1'b0;
    chk("busy_rst_ready", {31'b0, req_ready[2]}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("busy_rst_novalid", {31'b0, resp_valid[2]}, 32'd0);
    end
    tchk(2, 1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20_old", rd);
    chk("ld20_const", rd, 32'h11111111);

    // Reset during RESP drops the response but the store stays.
    model(2, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, rd, we);
    @(negedge clk);
    req_we[2] = 1'b1; req_addr[2] = 32'h24; req_wdata[2] = 32'hCAFEF00D; req_be[2] = 4'hF;
    req_valid[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid[2] = 1'b0;
    n = 0;
    while (!resp_valid[2] && n < 40) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk("resp_rst_latency", 32'(n), 32'd3);
    rst[2] = 1'b1; resp_ready[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst[2] = 1'b0; resp_ready[2] = 1'b0;
    chk("resp_rst_valid", {31'b0, resp_valid[2]}, 32'd0);
    chk("resp_rst_rdata", resp_rdata[2], 32'd0);
    tchk(2, 1'b0, 32'h24, 32'h0, 4'h0, 0, "ld24", rd);

    // LATENCY=1 randomized sweep.
    for (int i = 0; i < 100; i++) begin
      widx = int'($urandom_range(0, 63));
      we = mdl.exists(65536 + widx) ? 1'($urandom) : 1'b1;
      tchk(1, we, 32'(widx) << 2, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
           we ? "sw_st" : "sw_ld", rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
